dma_cfg_master: RTL
===================

Name: dma_cfg_master

Overview:
- Initiator side of the simple cfg MMIO interface; sits upstream of the top-level cfg port, where a host or command processor would otherwise be.
- Accepts one DMA command (src, dst, len) per handshake.
- Programs the DMA registers with single-beat cfg writes, issues the start write, then polls the status register until done or timeout.
- Reports completion or timeout to the command source.

Parameters:
- POLL_INTERVAL, 4, idle cycles between status polls; legal range ≥2; also the minimum delay from the start write to the first poll.
- TIMEOUT_CYCLES, 4096, cycles allowed in the poll phase before aborting; legal range ≥ POLL_INTERVAL+1.
- CNT_WIDTH, 16, width of the poll/timeout counters and xfer_count.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block idle, command accepted when cmd_valid & cmd_ready
- cmd_src  input  64  DMA source address
- cmd_dst  input  64  DMA destination address
- cmd_len  input  32  DMA length
- cfg_req_valid  output  1  cfg request valid
- cfg_req_addr  output  32  cfg register address
- cfg_req_wdata  output  32  cfg write data
- cfg_resp_valid  input  1  responder accepts/answers the request in the current cycle
- cfg_resp_rdata  input  32  read data; bit 0 = dma_done when address is 0x2C
- busy  output  1  command in progress
- done  output  1  one-cycle pulse: transfer completed
- timeout  output  1  one-cycle pulse: poll phase exceeded TIMEOUT_CYCLES
- xfer_count  output  CNT_WIDTH  completed transfers, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, rst_n low): state IDLE; cfg_req_valid=0, cfg_req_addr=0, cfg_req_wdata=0, busy=0, done=0, timeout=0, xfer_count=0; cmd_ready=1 once reset releases.
- Reset mid-operation: returns to IDLE immediately. Captured command is discarded; no done/timeout pulse.
- cfg_req_* are decoded from registered state and the command capture registers only; there is no combinational path from any input.
- States: IDLE, W_SRC_LO, W_SRC_HI, W_DST_LO, W_DST_HI, W_LEN, W_START, P_WAIT, P_READ, FIN, ERR.
- IDLE:
  - cmd_ready=1.
  - On accept, capture src/dst/len and set busy=1.
  - If cmd_len==0: go to FIN with no cfg traffic.
  - Otherwise go to W_SRC_LO.
- Write states drive cfg_req_valid=1 with these address/data pairs:
  - W_SRC_LO: 0x10, src[31:0]
  - W_SRC_HI: 0x14, src[63:32]
  - W_DST_LO: 0x18, dst[31:0]
  - W_DST_HI: 0x1C, dst[63:32]
  - W_LEN: 0x20, len
  - W_START: 0x24, 0x1
- Write advance and stall:
  - A beat completes at the rising edge where cfg_req_valid & cfg_resp_valid; the FSM moves to the next state.
  - While cfg_resp_valid=0 the request holds with addr/data stable.
  - With a same-cycle-echo responder each write takes exactly 1 cycle.
- P_WAIT:
  - cfg_req_valid=0.
  - Interval counter loads POLL_INTERVAL-1 on entry and decrements to 0, then moves to P_READ.
  - Entry from W_START therefore gives POLL_INTERVAL idle cycles.
- P_READ:
  - cfg_req_valid=1, addr=0x2C, wdata=0.
  - On cfg_resp_valid: rdata[0]=1 → FIN; rdata[0]=0 → P_WAIT.
- Timeout:
  - Counter clears on leaving W_START and increments every cycle in P_WAIT/P_READ.
  - When it reaches TIMEOUT_CYCLES → ERR. Timeout has priority over a same-cycle done read.
- FIN: done=1 for one cycle; xfer_count+1 (wraps); busy=0 next cycle; → IDLE.
- ERR: timeout=1 for one cycle; xfer_count unchanged; → IDLE.
- cmd_ready=0 in every state except IDLE.
- cmd_valid while busy is ignored; the command source holds it until it is accepted.
- Command-to-done latency with an echo responder and done set at the first poll: 1 (accept) + 6 (writes) + POLL_INTERVAL + 1 (read) + 1 (FIN).

Test Plan:
- Normal transfer: src=0x0000_0001_0000_1000, dst=0x0000_0002_0000_2000, len=64; echo responder, done=1 on first poll → write sequence (0x10,0x00001000),(0x14,1),(0x18,0x00002000),(0x1C,2),(0x20,64),(0x24,1), 4 idle cycles, read 0x2C, done pulse at cycle 13 after accept, xfer_count=1.
- Zero length: len=0 → no cfg_req_valid at all; done pulse 2 cycles after accept; xfer_count increments.
- Slow completion: rdata[0]=0 for the first 3 polls, then 1 → exactly 4 reads at 0x2C spaced POLL_INTERVAL+1 cycles apart, then done.
- Timeout: TIMEOUT_CYCLES=20, rdata[0] stuck 0 → timeout pulse exactly 20 cycles after W_START completes; no done; xfer_count unchanged; cmd_ready=1 the following cycle.
- Responder stall: cfg_resp_valid low 3 cycles during W_DST_HI → addr 0x1C and data held stable; sequence resumes with no beat skipped or duplicated.
- Reset mid-operation: assert rst_n=0 in P_WAIT → all outputs return to reset values asynchronously; next command runs the full sequence from 0x10.

Source files
------------

// File: rtl/dma_cfg_master_if.sv
// Single-beat cfg MMIO bus between a command-processor master and the DMA register block.
interface dma_cfg_master_if;
    logic        cfg_req_valid;
    logic [31:0] cfg_req_addr;
    logic [31:0] cfg_req_wdata;
    logic        cfg_resp_valid;
    logic [31:0] cfg_resp_rdata;

    modport master (
        output cfg_req_valid,
        output cfg_req_addr,
        output cfg_req_wdata,
        input  cfg_resp_valid,
        input  cfg_resp_rdata
    );

    modport slave (
        input  cfg_req_valid,
        input  cfg_req_addr,
        input  cfg_req_wdata,
        output cfg_resp_valid,
        output cfg_resp_rdata
    );
endinterface

// File: rtl/dma_cfg_master.sv
// Accepts one DMA command, programs the DMA registers over cfg, starts it and polls for done
// or timeout, then reports the outcome with a one-cycle pulse.
module dma_cfg_master #(
    parameter int unsigned POLL_INTERVAL  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [63:0]          cmd_src,
    input  logic [63:0]          cmd_dst,
    input  logic [31:0]          cmd_len,
    dma_cfg_master_if.master     cfg,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef enum logic [3:0] {
        StIdle,
        StWSrcLo,
        StWSrcHi,
        StWDstLo,
        StWDstHi,
        StWLen,
        StWStart,
        StPWait,
        StPRead,
        StFin,
        StErr
    } state_e;

    state_e               state_q, state_d;
    logic [63:0]          src_q, src_d;
    logic [63:0]          dst_q, dst_d;
    logic [31:0]          len_q, len_d;
    logic [CNT_WIDTH-1:0] icnt_q;
    logic [CNT_WIDTH-1:0] tcnt_q;
    logic [CNT_WIDTH-1:0] tcnt_inc;
    logic                 accept;
    logic                 tmo_hit;
    logic                 req_valid_d;
    logic [31:0]          req_addr_d;
    logic [31:0]          req_wdata_d;
    logic                 unused_rdata;

    assign accept   = (state_q == StIdle) && cmd_valid;
    assign tcnt_inc = tcnt_q + 1'b1;
    assign tmo_hit  = (tcnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign src_d    = accept ? cmd_src : src_q;
    assign dst_d    = accept ? cmd_dst : dst_q;
    assign len_d    = accept ? cmd_len : len_q;

    // Only the done flag of the status register matters here.
    assign unused_rdata = ^cfg.cfg_resp_rdata[31:1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = (cmd_len == '0) ? StFin : StWSrcLo;
                end
            end
            StWSrcLo: if (cfg.cfg_resp_valid) state_d = StWSrcHi;
            StWSrcHi: if (cfg.cfg_resp_valid) state_d = StWDstLo;
            StWDstLo: if (cfg.cfg_resp_valid) state_d = StWDstHi;
            StWDstHi: if (cfg.cfg_resp_valid) state_d = StWLen;
            StWLen:   if (cfg.cfg_resp_valid) state_d = StWStart;
            StWStart: if (cfg.cfg_resp_valid) state_d = StPWait;
            StPWait: begin
                if (tmo_hit) begin
                    state_d = StErr;
                end else if (icnt_q == '0) begin
                    state_d = StPRead;
                end
            end
            StPRead: begin
                // Timeout wins over a done flag returned in the same cycle.
                if (tmo_hit) begin
                    state_d = StErr;
                end else if (cfg.cfg_resp_valid) begin
                    state_d = cfg.cfg_resp_rdata[0] ? StFin : StPWait;
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request for the upcoming state, registered so the bus has no input-to-output path.
    always_comb begin
        req_valid_d = 1'b1;
        req_addr_d  = 32'h0;
        req_wdata_d = 32'h0;
        case (state_d)
            StWSrcLo: begin req_addr_d = 32'h10; req_wdata_d = src_d[31:0];  end
            StWSrcHi: begin req_addr_d = 32'h14; req_wdata_d = src_d[63:32]; end
            StWDstLo: begin req_addr_d = 32'h18; req_wdata_d = dst_d[31:0];  end
            StWDstHi: begin req_addr_d = 32'h1C; req_wdata_d = dst_d[63:32]; end
            StWLen:   begin req_addr_d = 32'h20; req_wdata_d = len_d;        end
            StWStart: begin req_addr_d = 32'h24; req_wdata_d = 32'h1;        end
            StPRead:  begin req_addr_d = 32'h2C; req_wdata_d = 32'h0;        end
            default:  req_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            src_q             <= '0;
            dst_q             <= '0;
            len_q             <= '0;
            icnt_q            <= '0;
            tcnt_q            <= '0;
            cfg.cfg_req_valid <= 1'b0;
            cfg.cfg_req_addr  <= '0;
            cfg.cfg_req_wdata <= '0;
            cmd_ready         <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            timeout           <= 1'b0;
            xfer_count        <= '0;
        end else begin
            state_q           <= state_d;
            src_q             <= src_d;
            dst_q             <= dst_d;
            len_q             <= len_d;
            cfg.cfg_req_valid <= req_valid_d;
            cfg.cfg_req_addr  <= req_addr_d;
            cfg.cfg_req_wdata <= req_wdata_d;
            cmd_ready         <= (state_d == StIdle);
            busy              <= (state_d != StIdle);
            done              <= (state_d == StFin);
            timeout           <= (state_d == StErr);
            if (state_d == StFin) begin
                xfer_count <= xfer_count + 1'b1;
            end
            if ((state_d == StPWait) && (state_q != StPWait)) begin
                icnt_q <= CNT_WIDTH'(POLL_INTERVAL - 1);
            end else if ((state_q == StPWait) && (icnt_q != '0)) begin
                icnt_q <= icnt_q - 1'b1;
            end
            if (state_q == StWStart) begin
                tcnt_q <= '0;
            end else if ((state_q == StPWait) || (state_q == StPRead)) begin
                tcnt_q <= tcnt_inc;
            end
        end
    end

endmodule
